// File: rtl/fetch_ctrl_if.sv
// Decode-to-fetch control bundle: decode-side inputs and fetch-side controls.
interface fetch_ctrl_if;
  logic       Start;
  logic       IsBranch;
  logic       CondFlag;
  logic [2:0] BrTarget;
  logic       MemReq;
  logic       Done;
  logic       Init;
  logic       Stall;
  logic       Branch;
  logic [2:0] Target;
  logic       Squash;
  logic       Halted;
  logic [7:0] BranchCount;

  // Controller side.
  modport slave (
    input  Start, IsBranch, CondFlag, BrTarget, MemReq, Done,
    output Init, Stall, Branch, Target, Squash, Halted, BranchCount
  );

  // Harness / decode side.
  modport master (
    output Start, IsBranch, CondFlag, BrTarget, MemReq, Done,
    input  Init, Stall, Branch, Target, Squash, Halted, BranchCount
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch control unit: start-up/halt sequencing, branch resolution,
// fixed-latency memory stalls, wrong-path squash and taken-branch counting.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | out of reset; PC forced to 0 and held until Start
// S_INIT    | Init held for INIT_CYCLES cycles after Start
// S_RUN     | normal fetch; controls follow decode combinationally
// S_MEMWAIT | remaining stall cycles of a load/store
// S_HALT    | program finished; waits for Start to restart
module fetch_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int MEM_LAT     = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  fetch_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_MEMWAIT,
    S_HALT
  } state_t;

  localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);
  // The MemReq cycle itself is the first stall cycle, so MEMWAIT covers MEM_LAT-1.
  localparam logic [3:0] MEM_LOAD  = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_squash;
  logic [7:0] r_br_cnt;
  logic       w_taken;

  assign w_taken = (r_state == S_RUN) && !bus.Done && !bus.MemReq &&
                   bus.IsBranch && bus.CondFlag;

  // Fetch controls: state-driven outside RUN, decode-driven by priority inside RUN.
  always_comb begin
    bus.Init        = 1'b0;
    bus.Stall       = 1'b0;
    bus.Branch      = 1'b0;
    bus.Target      = 3'b000;
    bus.Halted      = 1'b0;
    bus.Squash      = r_squash;
    bus.BranchCount = r_br_cnt;
    case (r_state)
      S_IDLE: begin
        bus.Init  = 1'b1;
        bus.Stall = 1'b1;
      end
      S_INIT: bus.Init = 1'b1;
      S_RUN: begin
        if (bus.Done || bus.MemReq) begin
          bus.Stall = 1'b1;
        end else if (w_taken) begin
          bus.Branch = 1'b1;
          bus.Target = bus.BrTarget;
        end
      end
      S_MEMWAIT: bus.Stall = 1'b1;
      S_HALT: begin
        bus.Halted = 1'b1;
        bus.Stall  = 1'b1;
      end
      default: begin
        bus.Init  = 1'b1;
        bus.Stall = 1'b1;
      end
    endcase
  end

  // Sequencing state, shared cycle counter, squash flag and branch counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_squash <= 1'b0;
      r_br_cnt <= 8'd0;
    end else begin
      r_squash <= w_taken;
      case (r_state)
        S_IDLE, S_HALT: begin
          if (bus.Start) begin
            r_state  <= S_INIT;
            r_cnt    <= INIT_LOAD;
            r_br_cnt <= 8'd0;
          end
        end
        S_INIT, S_MEMWAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RUN;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RUN: begin
          if (bus.Done) begin
            r_state <= S_HALT;
          end else if (bus.MemReq) begin
            if (MEM_LAT > 1) begin
              r_state <= S_MEMWAIT;
              r_cnt   <= MEM_LOAD;
            end
          end else if (w_taken && (r_br_cnt != 8'hFF)) begin
            r_br_cnt <= r_br_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: two instances (MEM_LAT=3 and MEM_LAT=1) share one
// random/directed stimulus stream and are compared every cycle against a
// cycle-count model, with literal expectations pinning key scenarios.
module tb_fetch_ctrl;
  localparam int INIT_C = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       s_start, s_isbr, s_cond, s_mem, s_done;
  logic [2:0] s_tgt;

  fetch_ctrl_if bus0();
  fetch_ctrl_if bus1();

  assign bus0.Start = s_start;  assign bus1.Start = s_start;
  assign bus0.IsBranch = s_isbr; assign bus1.IsBranch = s_isbr;
  assign bus0.CondFlag = s_cond; assign bus1.CondFlag = s_cond;
  assign bus0.BrTarget = s_tgt;  assign bus1.BrTarget = s_tgt;
  assign bus0.MemReq = s_mem;    assign bus1.MemReq = s_mem;
  assign bus0.Done = s_done;     assign bus1.Done = s_done;

  fetch_ctrl #(.INIT_CYCLES(INIT_C), .MEM_LAT(3)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave));
  fetch_ctrl #(.INIT_CYCLES(INIT_C), .MEM_LAT(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));

  int n_checks = 0;
  int n_err    = 0;

  // Model: remaining Init cycles, remaining extra stall cycles, halted/idle flags.
  int lat[2] = '{3, 1};
  bit m_idle[2], m_halted[2], m_prevbr[2], m_brnow[2];
  int m_init[2], m_stall[2], m_cnt[2];

  task automatic cmp(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_idle[i] = 1; m_halted[i] = 0; m_prevbr[i] = 0; m_brnow[i] = 0;
      m_init[i] = 0; m_stall[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic check_inst(input int i, input logic a_init, input logic a_stall,
                            input logic a_br, input logic [2:0] a_tgt, input logic a_sq,
                            input logic a_halt, input logic [7:0] a_cnt);
    logic e_init, e_stall, e_br, e_halt;
    logic [2:0] e_tgt;
    e_init = 0; e_stall = 0; e_br = 0; e_halt = 0; e_tgt = 3'b000;
    if (m_idle[i]) begin
      e_init = 1; e_stall = 1;
    end else if (m_init[i] > 0) begin
      e_init = 1;
    end else if (m_halted[i]) begin
      e_halt = 1; e_stall = 1;
    end else if (m_stall[i] > 0) begin
      e_stall = 1;
    end else if (s_done || s_mem) begin
      e_stall = 1;
    end else if (s_isbr && s_cond) begin
      e_br = 1; e_tgt = s_tgt;
    end
    m_brnow[i] = e_br;
    cmp("Init", i, {7'd0, a_init}, {7'd0, e_init});
    cmp("Stall", i, {7'd0, a_stall}, {7'd0, e_stall});
    cmp("Branch", i, {7'd0, a_br}, {7'd0, e_br});
    cmp("Target", i, {5'd0, a_tgt}, {5'd0, e_tgt});
    cmp("Squash", i, {7'd0, a_sq}, {7'd0, m_prevbr[i]});
    cmp("Halted", i, {7'd0, a_halt}, {7'd0, e_halt});
    cmp("BranchCount", i, a_cnt, 8'(m_cnt[i]));
  endtask

  task automatic model_step(input int i);
    m_prevbr[i] = m_brnow[i];
    if (m_idle[i] || m_halted[i]) begin
      if (s_start) begin
        m_idle[i] = 0; m_halted[i] = 0; m_init[i] = INIT_C; m_cnt[i] = 0;
      end
    end else if (m_init[i] > 0) begin
      m_init[i]--;
    end else if (m_stall[i] > 0) begin
      m_stall[i]--;
    end else if (s_done) begin
      m_halted[i] = 1;
    end else if (s_mem) begin
      m_stall[i] = lat[i] - 1;
    end else if (s_isbr && s_cond) begin
      if (m_cnt[i] < 255) m_cnt[i]++;
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, return just after it.
  task automatic cycle();
    @(negedge clk);
    check_inst(0, bus0.Init, bus0.Stall, bus0.Branch, bus0.Target, bus0.Squash, bus0.Halted, bus0.BranchCount);
    check_inst(1, bus1.Init, bus1.Stall, bus1.Branch, bus1.Target, bus1.Squash, bus1.Halted, bus1.BranchCount);
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end else begin
      model_reset();
    end
    #1;
  endtask

  task automatic clear_in();
    s_start = 0; s_isbr = 0; s_cond = 0; s_tgt = 3'b000; s_mem = 0; s_done = 0;
  endtask

  int k, k1;

  initial begin
    clear_in();
    model_reset();
    rst_n = 0;
    #12;
    cmp("rst_Init", 0, {7'd0, bus0.Init}, 8'd1);
    cmp("rst_Stall", 0, {7'd0, bus0.Stall}, 8'd1);
    cmp("rst_BranchCount", 0, bus0.BranchCount, 8'd0);
    cycle();
    rst_n = 1;
    cycle();
    cycle();

    // Start: Init high for exactly INIT_C cycles after the edge.
    s_start = 1;
    cycle();
    s_start = 0;
    k = 0;
    for (int j = 0; j < 10; j++) begin
      if (bus0.Init) k++;
      cycle();
    end
    cmp("init_len", 0, 8'(k), 8'd2);
    cmp("run_Stall", 0, {7'd0, bus0.Stall}, 8'd0);

    // Taken branch, then not-taken.
    s_isbr = 1; s_cond = 1; s_tgt = 3'b110;
    #1;
    cmp("taken_Branch", 0, {7'd0, bus0.Branch}, 8'd1);
    cmp("taken_Target", 0, {5'd0, bus0.Target}, 8'b110);
    cycle();
    clear_in();
    #1;
    cmp("taken_Squash", 0, {7'd0, bus0.Squash}, 8'd1);
    cmp("taken_Count", 0, bus0.BranchCount, 8'd1);
    cycle();
    s_isbr = 1; s_cond = 0; s_tgt = 3'b101;
    #1;
    cmp("nt_Branch", 0, {7'd0, bus0.Branch}, 8'd0);
    cmp("nt_Target", 0, {5'd0, bus0.Target}, 8'd0);
    cycle();
    clear_in();
    #1;
    cmp("nt_Squash", 0, {7'd0, bus0.Squash}, 8'd0);

    // Memory stall length on both latencies.
    s_mem = 1;
    k = 0; k1 = 0;
    for (int j = 0; j < 6; j++) begin
      #1;
      if (bus0.Stall) k++;
      if (bus1.Stall) k1++;
      cycle();
      s_mem = 0;
    end
    cmp("stall_len_lat3", 0, 8'(k), 8'd3);
    cmp("stall_len_lat1", 1, 8'(k1), 8'd1);

    // MemReq overrides a taken branch.
    s_mem = 1; s_isbr = 1; s_cond = 1; s_tgt = 3'b011;
    #1;
    cmp("mem_over_br", 0, {7'd0, bus0.Branch}, 8'd0);
    cycle();
    clear_in();
    repeat (4) cycle();

    // Done with MemReq halts directly; restart clears the count.
    s_done = 1; s_mem = 1;
    cycle();
    clear_in();
    #1;
    cmp("halt_Halted", 0, {7'd0, bus0.Halted}, 8'd1);
    cmp("halt_Stall", 0, {7'd0, bus0.Stall}, 8'd1);
    cmp("halt_Halted_lat1", 1, {7'd0, bus1.Halted}, 8'd1);
    cycle();
    s_start = 1;
    cycle();
    s_start = 0;
    #1;
    cmp("restart_Init", 0, {7'd0, bus0.Init}, 8'd1);
    cmp("restart_Count", 0, bus0.BranchCount, 8'd0);
    repeat (3) cycle();

    // Saturation after 260 taken branches.
    s_isbr = 1; s_cond = 1;
    for (int j = 0; j < 260; j++) begin
      s_tgt = 3'($urandom);
      cycle();
    end
    clear_in();
    #1;
    cmp("sat_Count", 0, bus0.BranchCount, 8'd255);

    // Reset in the middle of a memory stall.
    s_mem = 1;
    cycle();
    s_mem = 0;
    cycle();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    cmp("rstmw_Init", 0, {7'd0, bus0.Init}, 8'd1);
    cmp("rstmw_Stall", 0, {7'd0, bus0.Stall}, 8'd1);
    cmp("rstmw_Branch", 0, {7'd0, bus0.Branch}, 8'd0);
    cmp("rstmw_Halted", 0, {7'd0, bus0.Halted}, 8'd0);
    cmp("rstmw_Count", 0, bus0.BranchCount, 8'd0);
    cycle();
    rst_n = 1;
    cycle();

    // Random traffic with occasional async resets.
    for (int j = 0; j < 3000; j++) begin
      s_start = ($urandom_range(0, 9) == 0);
      s_done  = ($urandom_range(0, 49) == 0);
      s_mem   = ($urandom_range(0, 7) == 0);
      s_isbr  = ($urandom_range(0, 9) < 4);
      s_cond  = $urandom_range(0, 1) == 1;
      s_tgt   = 3'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 0;
        model_reset();
        cycle();
        rst_n = 1;
      end else begin
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Control unit that drives the instruction-fetch unit's Init, Stall, Branch and Target inputs.
- Sequences program start-up and halt.
- Resolves conditional branches from decode into a 3-bit signed word-of-4 offset.
- Inserts fixed-latency stall windows for memory instructions, squashes the wrong-path fetch after a taken branch, and counts taken branches for the test harness.

Parameters:
- INIT_CYCLES, 2, cycles Init is held after Start (legal 1..15).
- MEM_LAT, 3, total stall cycles per load/store (legal 1..15).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_n  in  1  reset, asynchronous, active-low.
- Start  in  1  pulse; begins a program from IDLE or HALT.
- IsBranch  in  1  decoded instruction is a conditional branch.
- CondFlag  in  1  branch condition result, valid with IsBranch.
- BrTarget  in  3  signed branch offset field (IF scales it by 4).
- MemReq  in  1  decoded instruction is a load/store.
- Done  in  1  decoded instruction is halt.
- Init  out  1  forces fetch PC to 0.
- Stall  out  1  holds fetch PC.
- Branch  out  1  take branch this cycle.
- Target  out  3  offset to IF; equals BrTarget when Branch=1, else 3'b000.
- Squash  out  1  kill the instruction fetched the cycle after a taken branch.
- Halted  out  1  program finished.
- BranchCount  out  8  taken-branch count, saturating.

Behaviour:
- Reset (RST_n=0, any time, including mid-stall): state IDLE, counters cleared. Outputs: Init=1, Stall=1, Branch=0, Target=0, Squash=0, Halted=0, BranchCount=0. Release is effective at the first posedge with RST_n=1.
- States: IDLE, INIT, RUN, MEMWAIT, HALT (registered); 4-bit cycle counter.
- IDLE
  - Outputs: Init=1, Stall=1, Halted=0.
  - Start=1 -> INIT; counter loads INIT_CYCLES-1; BranchCount cleared.
- INIT
  - Outputs: Init=1, Stall=0.
  - Counter decrements each cycle; at 0 -> RUN. Init is therefore high for exactly INIT_CYCLES cycles after the Start edge.
- RUN
  - Init=0. Branch/Stall/Target are combinational from the decode inputs in the same cycle. Priority, highest first:
  - Done=1: Stall=1, Branch=0; next state HALT.
  - MemReq=1: Stall=1, Branch=0 (IsBranch ignored).
    - MEM_LAT=1: stay in RUN.
    - Otherwise: -> MEMWAIT with counter = MEM_LAT-2.
  - IsBranch & CondFlag: Branch=1, Target=BrTarget, Stall=0.
    - Squash=1 on the next cycle only (registered).
    - BranchCount increments, saturating at 255.
  - IsBranch & ~CondFlag: Branch=0, Stall=0, no count.
  - Otherwise: all control outputs 0 (IF increments PC).
- MEMWAIT
  - Outputs: Stall=1, Branch=0; decode inputs ignored.
  - Counter decrements; at 0 -> RUN. Total Stall cycles, including the MemReq cycle in RUN, = MEM_LAT.
- HALT
  - Outputs: Halted=1, Stall=1, Init=0, Branch=0.
  - Start=1 -> INIT (restart; BranchCount cleared).
- Start is ignored in INIT, RUN and MEMWAIT.
- Squash
  - Registered: 1 exactly one cycle after any cycle with Branch=1.
  - Cleared on reset; never asserted in IDLE/INIT.
  - Back-to-back taken branches: Squash remains 1 for each following cycle.
- Target sign: BrTarget is passed unmodified. IF performs the sign extension and the <<2, so 3'b111 means -4 and 3'b011 means +12.

Test Plan:
- Reset mid-MEMWAIT: MEM_LAT=3, MemReq, pull RST_n low after 1 cycle -> outputs immediately Init=1, Stall=1, Branch=0, Halted=0; state IDLE; BranchCount=0.
- Start sequencing: INIT_CYCLES=2, Start pulse -> Init=1 for 2 cycles after the edge, then RUN with Init=0, Stall=0.
- Taken/not-taken branch:
  - IsBranch=1, CondFlag=1, BrTarget=3'b110 -> same cycle Branch=1, Target=110; next cycle Squash=1; BranchCount=1.
  - CondFlag=0 -> Branch=0, Target=000, no Squash.
- Memory stall:
  - MEM_LAT=3, single MemReq -> Stall=1 for exactly 3 consecutive cycles, then 0.
  - MemReq together with IsBranch&CondFlag -> Branch stays 0.
  - MEM_LAT=1 -> exactly 1 stall cycle.
- Halt/restart: Done=1 together with MemReq -> next cycle Halted=1, Stall=1, no MEMWAIT; Start -> INIT, BranchCount cleared to 0.
- Saturation: 260 taken branches -> BranchCount=255, no wrap.
